// File: rtl/mrpnwp_pkg.sv
// Shared definitions for the mrpnwp memory adapter slice.
//   state_t      : adapter FSM state (INIT zero-fill sweep, RUN normal traffic)
//   vadr2padr    : virtual address -> {bank,row} physical address
//   padr_cfg_ok  : checks the physical address width against bank/row widths
package mrpnwp_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bank is taken from the low address bits so consecutive addresses spread
   // across banks; the remaining high bits select the row.
   function automatic logic [31:0] vadr2padr(input logic [31:0] adr,
                                             input int          bitvbnk,
                                             input int          bitvrow);
      logic [31:0] bank;
      logic [31:0] row;
      bank = adr & ((32'd1 << bitvbnk) - 32'd1);
      row  = (adr >> bitvbnk) & ((32'd1 << bitvrow) - 32'd1);
      return (bank << bitvrow) | row;
   endfunction

   function automatic bit padr_cfg_ok(input int bitpadr,
                                      input int bitvbnk,
                                      input int bitvrow);
      return bitpadr == (bitvbnk + bitvrow);
   endfunction

endpackage

// File: rtl/mrpnwp_mem_adapter_if.sv
// Bus bundle between the core wrapper, the adapter and the 1R1W macro.
//   core -> adapter : pread, rdadr, pwrite, wradr, pdin
//   adapter -> macro: t1_writeA, t1_addrA, t1_dinA, t1_readB, t1_addrB
//   macro -> adapter: mem_doutB
//   adapter -> core : t1_doutB, vread_vld_bus, vread_padr_bus, wr_conflict, init_done
// modport slave is the adapter; modport master is the surrounding core/macro side.
interface mrpnwp_mem_adapter_if #(
   parameter int WIDTH   = 32,
   parameter int NUMRDPT = 2,
   parameter int NUMWRPT = 3,
   parameter int BITADDR = 13,
   parameter int BITPADR = 13
);
   logic [NUMRDPT-1:0]         pread;
   logic [NUMRDPT*BITADDR-1:0] rdadr;
   logic [NUMWRPT-1:0]         pwrite;
   logic [NUMWRPT*BITADDR-1:0] wradr;
   logic [NUMWRPT*WIDTH-1:0]   pdin;
   logic [NUMWRPT-1:0]         t1_writeA;
   logic [NUMWRPT*BITPADR-1:0] t1_addrA;
   logic [NUMWRPT*WIDTH-1:0]   t1_dinA;
   logic [NUMRDPT-1:0]         t1_readB;
   logic [NUMRDPT*BITPADR-1:0] t1_addrB;
   logic [NUMRDPT*WIDTH-1:0]   mem_doutB;
   logic [NUMRDPT*WIDTH-1:0]   t1_doutB;
   logic [NUMRDPT-1:0]         vread_vld_bus;
   logic [NUMRDPT*BITPADR-1:0] vread_padr_bus;
   logic                       wr_conflict;
   logic                       init_done;

   modport slave (
      input  pread, rdadr, pwrite, wradr, pdin, mem_doutB,
      output t1_writeA, t1_addrA, t1_dinA, t1_readB, t1_addrB,
      output t1_doutB, vread_vld_bus, vread_padr_bus, wr_conflict, init_done
   );

   modport master (
      output pread, rdadr, pwrite, wradr, pdin, mem_doutB,
      input  t1_writeA, t1_addrA, t1_dinA, t1_readB, t1_addrB,
      input  t1_doutB, vread_vld_bus, vread_padr_bus, wr_conflict, init_done
   );
endinterface

// File: rtl/mrpnwp_rd_dly.sv
// One read port's valid/physical-address delay line, matched to the macro
// read latency so the returned data lines up with its request.
//   clk, rst : clock, synchronous active-high reset (flushes the line)
//   i_vld    : read issued to the macro this cycle
//   i_padr   : physical address of that read (0 when not reading)
//   o_vld    : read data from the macro is valid this cycle
//   o_padr   : physical address belonging to the returned data
module mrpnwp_rd_dly #(
   parameter int BITPADR    = 13,
   parameter int SRAM_DELAY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_vld,
   input  logic [BITPADR-1:0] i_padr,
   output logic               o_vld,
   output logic [BITPADR-1:0] o_padr
);

   logic [SRAM_DELAY-1:0] r_vld_p;
   logic [BITPADR-1:0]    r_padr_p [SRAM_DELAY];

   // stage 0 captures the issued read; each later stage is one more macro cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p <= '0;
         for (int k = 0; k < SRAM_DELAY; k++) r_padr_p[k] <= '0;
      end else begin
         r_vld_p[0]  <= i_vld;
         r_padr_p[0] <= i_padr;
         for (int k = 1; k < SRAM_DELAY; k++) begin
            r_vld_p[k]  <= r_vld_p[k-1];
            r_padr_p[k] <= r_padr_p[k-1];
         end
      end
   end

   assign o_vld  = r_vld_p[SRAM_DELAY-1];
   assign o_padr = r_padr_p[SRAM_DELAY-1];

endmodule

// File: rtl/mrpnwp_mem_adapter.sv
// Memory-side stage of the multi-read/multi-write wrapper. Maps virtual
// addresses onto {bank,row}, drives the 1R1W macro ports, aligns read
// returns with the macro latency and zero-fills the array after reset.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mrpnwp_mem_adapter_if.slave (core strobes, macro ports,
//              read returns, wr_conflict, init_done)
module mrpnwp_mem_adapter
   import mrpnwp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUMRDPT    = 2,
   parameter int NUMWRPT    = 3,
   parameter int NUMADDR    = 8192,
   parameter int BITADDR    = 13,
   parameter int NUMVROW    = 1024,
   parameter int BITVROW    = 10,
   parameter int NUMVBNK    = 8,
   parameter int BITVBNK    = 3,
   parameter int BITPADR    = 13,
   parameter int SRAM_DELAY = 2
) (
   input logic                 clk,
   input logic                 rst,
   mrpnwp_mem_adapter_if.slave bus
);

   localparam bit CFG_OK = padr_cfg_ok(BITPADR, BITVBNK, BITVROW)
                           && (NUMADDR <= NUMVBNK * NUMVROW) && (SRAM_DELAY >= 1);
   localparam logic [BITADDR:0] ICNT_LAST = (BITADDR+1)'(NUMADDR - 1);

   if (!CFG_OK) begin : g_cfg_err
      $error("mrpnwp_mem_adapter: inconsistent address/latency parameters");
   end

   state_t             r_state, w_state_nxt;
   logic [BITADDR:0]   r_icnt, w_icnt_nxt;
   logic               r_wr_conflict, w_conflict;
   logic               w_sup;
   logic [NUMRDPT-1:0] w_rd_vld, w_tail_vld;
   logic [BITPADR-1:0] w_rd_padr   [NUMRDPT];
   logic [BITPADR-1:0] w_tail_padr [NUMRDPT];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= INIT;
         r_icnt        <= '0;
         r_wr_conflict <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_icnt        <= w_icnt_nxt;
         r_wr_conflict <= w_conflict;
      end
   end

   // Macro strobes are forced low while rst is high so nothing reaches the
   // array in the reset cycle, whatever state the FSM is leaving.
   always_comb begin
      w_state_nxt   = r_state;
      w_icnt_nxt    = r_icnt;
      w_conflict    = 1'b0;
      w_sup         = 1'b0;
      bus.t1_writeA = '0;
      bus.t1_addrA  = '0;
      bus.t1_dinA   = '0;
      bus.t1_readB  = '0;
      bus.t1_addrB  = '0;
      w_rd_vld      = '0;
      for (int i = 0; i < NUMRDPT; i++) w_rd_padr[i] = '0;

      if (r_state == INIT) begin
         w_icnt_nxt = r_icnt + 1'b1;
         if (r_icnt == ICNT_LAST) w_state_nxt = RUN;
         if (!rst) begin
            bus.t1_writeA[0]           = 1'b1;
            bus.t1_addrA[0 +: BITPADR] = BITPADR'(vadr2padr(32'(r_icnt), BITVBNK, BITVROW));
         end
      end else if (!rst) begin
         for (int i = 0; i < NUMWRPT; i++) begin
            if (bus.pwrite[i]) begin
               // a higher-index port writing the same address wins
               w_sup = 1'b0;
               for (int j = i + 1; j < NUMWRPT; j++) begin
                  if (bus.pwrite[j] &&
                      bus.wradr[j*BITADDR +: BITADDR] == bus.wradr[i*BITADDR +: BITADDR])
                     w_sup = 1'b1;
               end
               if (w_sup) begin
                  w_conflict = 1'b1;
               end else begin
                  bus.t1_writeA[i] = 1'b1;
                  bus.t1_addrA[i*BITPADR +: BITPADR] =
                     BITPADR'(vadr2padr(32'(bus.wradr[i*BITADDR +: BITADDR]), BITVBNK, BITVROW));
                  bus.t1_dinA[i*WIDTH +: WIDTH] = bus.pdin[i*WIDTH +: WIDTH];
               end
            end
         end
         for (int i = 0; i < NUMRDPT; i++) begin
            if (bus.pread[i]) begin
               bus.t1_readB[i] = 1'b1;
               w_rd_vld[i]     = 1'b1;
               w_rd_padr[i]    =
                  BITPADR'(vadr2padr(32'(bus.rdadr[i*BITADDR +: BITADDR]), BITVBNK, BITVROW));
               bus.t1_addrB[i*BITPADR +: BITPADR] = w_rd_padr[i];
            end
         end
      end
   end

   for (genvar g = 0; g < NUMRDPT; g++) begin : g_rd
      mrpnwp_rd_dly #(
         .BITPADR    (BITPADR),
         .SRAM_DELAY (SRAM_DELAY)
      ) u_rd_dly (
         .clk    (clk),
         .rst    (rst),
         .i_vld  (w_rd_vld[g]),
         .i_padr (w_rd_padr[g]),
         .o_vld  (w_tail_vld[g]),
         .o_padr (w_tail_padr[g])
      );
   end

   always_comb begin
      bus.vread_padr_bus = '0;
      bus.t1_doutB       = '0;
      for (int i = 0; i < NUMRDPT; i++) begin
         bus.vread_padr_bus[i*BITPADR +: BITPADR] = w_tail_padr[i];
         if (w_tail_vld[i]) bus.t1_doutB[i*WIDTH +: WIDTH] = bus.mem_doutB[i*WIDTH +: WIDTH];
      end
   end

   assign bus.vread_vld_bus = w_tail_vld;
   assign bus.wr_conflict   = r_wr_conflict;
   assign bus.init_done     = (r_state == RUN);

endmodule

// File: tb/tb_mrpnwp_mem_adapter.sv
// Directed bench for mrpnwp_mem_adapter with a 16-entry array
// (8 banks x 2 rows) and a 2-cycle behavioural 1R1W macro.
module tb_mrpnwp_mem_adapter;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mrpnwp_mem_adapter_if #(.WIDTH(W), .NUMRDPT(2), .NUMWRPT(3), .BITADDR(4), .BITPADR(4)) bus ();

   mrpnwp_mem_adapter #(
      .WIDTH(W), .NUMRDPT(2), .NUMWRPT(3), .NUMADDR(16), .BITADDR(4),
      .NUMVROW(2), .BITVROW(1), .NUMVBNK(8), .BITVBNK(3), .BITPADR(4), .SRAM_DELAY(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // behavioural macro: writes land at the edge, reads see pre-write data
   logic [W-1:0] mem [16];
   logic [W-1:0] rq0 [2];
   logic [W-1:0] rq1 [2];

   initial for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD0000 | 32'(i);

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (bus.t1_writeA[i]) mem[bus.t1_addrA[i*4 +: 4]] <= bus.t1_dinA[i*W +: W];
      for (int i = 0; i < 2; i++) begin
         rq0[i] <= mem[bus.t1_addrB[i*4 +: 4]];
         rq1[i] <= rq0[i];
      end
   end
   assign bus.mem_doutB = {rq1[1], rq1[0]};

   // vaddr -> {bank,row}: bank=a[2:0], row=a[3]
   logic [3:0] pmap [16];
   // array contents by virtual address after the directed table
   logic [W-1:0] vmem [16];

   typedef struct {
      logic [1:0]   rd;
      logic [3:0]   ra0, ra1;
      logic [2:0]   wr;
      logic [3:0]   wa0, wa1, wa2;
      logic [W-1:0] d0, d1, d2;
      logic [2:0]   e_wa;
      logic [1:0]   e_rb;
      logic [1:0]   e_vld;
      logic [3:0]   e_pa0, e_pa1;
      logic [W-1:0] e_do0, e_do1;
      logic         e_cf;
   } vec_t;

   vec_t tbl [23];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1;
      pmap = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14,
               4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
      vmem = '{32'h0, 32'h0, 32'h2222, 32'h0, 32'h4444, 32'h5555, 32'h6666, 32'h7777,
               32'h8888, 32'h9999, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      //          rd     ra0   ra1   wr      wa0   wa1   wa2   d0          d1          d2          e_wa    e_rb   e_vld  pa0    pa1    do0         do1         cf
      tbl[0]  = '{2'b00, 4'd0, 4'd0, 3'b010, 4'd0, 4'd5, 4'd0, 32'h0,      32'hA5A5,   32'h0,      3'b010, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[1]  = '{2'b01, 4'd5, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b01, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[2]  = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[3]  = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b01, 4'd10, 4'd0,  32'hA5A5,   32'h0,      1'b0};
      tbl[4]  = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[5]  = '{2'b00, 4'd0, 4'd0, 3'b111, 4'd9, 4'd2, 4'd9, 32'h1111,   32'h2222,   32'h9999,   3'b110, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[6]  = '{2'b11, 4'd2, 4'd9, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b11, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b1};
      tbl[7]  = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[8]  = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b11, 4'd4,  4'd3,  32'h2222,   32'h9999,   1'b0};
      tbl[9]  = '{2'b10, 4'd0, 4'd5, 3'b001, 4'd5, 4'd0, 4'd0, 32'h5555,   32'h0,      32'h0,      3'b001, 2'b10, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[10] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[11] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b10, 4'd0,  4'd10, 32'h0,      32'hA5A5,   1'b0};
      tbl[12] = '{2'b10, 4'd0, 4'd5, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b10, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[13] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[14] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b10, 4'd0,  4'd10, 32'h0,      32'h5555,   1'b0};
      tbl[15] = '{2'b00, 4'd0, 4'd0, 3'b111, 4'd7, 4'd7, 4'd7, 32'h7001,   32'h7002,   32'h7777,   3'b100, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[16] = '{2'b01, 4'd7, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b01, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b1};
      tbl[17] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[18] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b01, 4'd14, 4'd0,  32'h7777,   32'h0,      1'b0};
      tbl[19] = '{2'b00, 4'd0, 4'd0, 3'b001, 4'd4, 4'd4, 4'd0, 32'h4444,   32'h0,      32'h0,      3'b001, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[20] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[21] = '{2'b00, 4'd0, 4'd0, 3'b111, 4'd6, 4'd6, 4'd8, 32'h6001,   32'h6666,   32'h8888,   3'b110, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b0};
      tbl[22] = '{2'b00, 4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 4'd0, 32'h0,      32'h0,      32'h0,      3'b000, 2'b00, 2'b00, 4'd0,  4'd0,  32'h0,      32'h0,      1'b1};

      bus.pread = '0; bus.rdadr = '0; bus.pwrite = '0; bus.wradr = '0; bus.pdin = '0;

      // reset cycle with core strobes already high
      tick();
      tick();
      bus.pread  = 2'b11;
      bus.rdadr  = {4'd1, 4'd1};
      bus.pwrite = 3'b111;
      bus.wradr  = {4'd3, 4'd3, 4'd3};
      bus.pdin   = {32'h33, 32'h22, 32'h11};
      #1;
      chk("rst init_done", 64'(bus.init_done), 64'd0);
      chk("rst vld", 64'(bus.vread_vld_bus), 64'd0);
      chk("rst padr", 64'(bus.vread_padr_bus), 64'd0);
      chk("rst doutB", 64'(bus.t1_doutB), 64'd0);
      chk("rst conflict", 64'(bus.wr_conflict), 64'd0);
      chk("rst writeA", 64'(bus.t1_writeA), 64'd0);
      chk("rst readB", 64'(bus.t1_readB), 64'd0);

      // zero-fill sweep, core strobes held high and ignored
      for (int k = 0; k < 16; k++) begin
         tick();
         rst = 1'b0;
         #1;
         chk($sformatf("init%0d writeA", k), 64'(bus.t1_writeA), 64'b001);
         chk($sformatf("init%0d addrA0", k), 64'(bus.t1_addrA[3:0]), 64'(pmap[k]));
         chk($sformatf("init%0d dinA0", k), 64'(bus.t1_dinA[W-1:0]), 64'd0);
         chk($sformatf("init%0d readB", k), 64'(bus.t1_readB), 64'd0);
         chk($sformatf("init%0d init_done", k), 64'(bus.init_done), 64'd0);
         chk($sformatf("init%0d vld", k), 64'(bus.vread_vld_bus), 64'd0);
      end
      tick();
      bus.pread = '0; bus.pwrite = '0;
      #1;
      chk("run init_done", 64'(bus.init_done), 64'd1);
      chk("run writeA", 64'(bus.t1_writeA), 64'd0);
      chk("run vld", 64'(bus.vread_vld_bus), 64'd0);
      chk("run conflict", 64'(bus.wr_conflict), 64'd0);

      // directed cycle table
      for (int r = 0; r < 23; r++) begin
         tick();
         bus.pread  = tbl[r].rd;
         bus.rdadr  = {tbl[r].ra1, tbl[r].ra0};
         bus.pwrite = tbl[r].wr;
         bus.wradr  = {tbl[r].wa2, tbl[r].wa1, tbl[r].wa0};
         bus.pdin   = {tbl[r].d2, tbl[r].d1, tbl[r].d0};
         #1;
         chk($sformatf("row%0d writeA", r), 64'(bus.t1_writeA), 64'(tbl[r].e_wa));
         chk($sformatf("row%0d readB", r), 64'(bus.t1_readB), 64'(tbl[r].e_rb));
         chk($sformatf("row%0d vld", r), 64'(bus.vread_vld_bus), 64'(tbl[r].e_vld));
         chk($sformatf("row%0d padr", r), 64'(bus.vread_padr_bus), 64'({tbl[r].e_pa1, tbl[r].e_pa0}));
         chk($sformatf("row%0d doutB", r), 64'(bus.t1_doutB), {tbl[r].e_do1, tbl[r].e_do0});
         chk($sformatf("row%0d conflict", r), 64'(bus.wr_conflict), 64'(tbl[r].e_cf));
      end

      // back-to-back reads on both ports for 20 cycles
      n0 = 0; n1 = 0;
      for (int c = 0; c < 23; c++) begin
         tick();
         bus.pwrite = '0;
         bus.pread  = (c < 20) ? 2'b11 : 2'b00;
         bus.rdadr  = {4'((c + 3) & 15), 4'(c & 15)};
         #1;
         n0 += int'(bus.vread_vld_bus[0]);
         n1 += int'(bus.vread_vld_bus[1]);
         if (c >= 2 && c < 22) begin
            chk($sformatf("b2b%0d vld", c), 64'(bus.vread_vld_bus), 64'b11);
            chk($sformatf("b2b%0d padr", c), 64'(bus.vread_padr_bus),
                64'({pmap[(c + 1) & 15], pmap[(c - 2) & 15]}));
            chk($sformatf("b2b%0d doutB", c), 64'(bus.t1_doutB),
                {vmem[(c + 1) & 15], vmem[(c - 2) & 15]});
         end else begin
            chk($sformatf("b2b%0d vld", c), 64'(bus.vread_vld_bus), 64'b00);
            chk($sformatf("b2b%0d doutB", c), 64'(bus.t1_doutB), 64'd0);
         end
      end
      chk("b2b count p0", 64'(n0), 64'd20);
      chk("b2b count p1", 64'(n1), 64'd20);

      // read in flight when rst arrives
      tick();
      bus.pread = 2'b01;
      bus.rdadr = {4'd0, 4'd5};
      #1;
      chk("flush issue readB", 64'(bus.t1_readB), 64'b01);
      tick();
      rst = 1'b1;
      #1;
      chk("flush rst readB", 64'(bus.t1_readB), 64'd0);
      chk("flush rst writeA", 64'(bus.t1_writeA), 64'd0);
      tick();
      rst = 1'b0;
      bus.pread = '0;
      #1;
      chk("flush T+2 vld", 64'(bus.vread_vld_bus), 64'd0);
      chk("flush T+2 doutB", 64'(bus.t1_doutB), 64'd0);
      chk("flush init_done", 64'(bus.init_done), 64'd0);
      chk("flush writeA", 64'(bus.t1_writeA), 64'b001);
      chk("flush addrA icnt0", 64'(bus.t1_addrA[3:0]), 64'(pmap[0]));
      tick();
      #1;
      chk("flush T+3 vld", 64'(bus.vread_vld_bus), 64'd0);
      chk("flush addrA icnt1", 64'(bus.t1_addrA[3:0]), 64'(pmap[1]));
      for (int k = 2; k < 16; k++) tick();
      #1;
      chk("reinit last init_done", 64'(bus.init_done), 64'd0);
      chk("reinit last addrA", 64'(bus.t1_addrA[3:0]), 64'(pmap[15]));
      tick();
      #1;
      chk("reinit init_done", 64'(bus.init_done), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mrpnwp_mem_adapter.md
# mrpnwp_mem_adapter

Memory-side stage directly downstream of the multi-read/multi-write core wrapper. It consumes the gated `pread`/`pwrite`/`pdin` strobes, maps virtual addresses onto bank/row physical addresses, and drives the 1R1W macro ports. It pipelines read valid and physical address to align with the macro's `SRAM_DELAY` latency, then returns `t1_doutB`, `vread_vld_bus` and `vread_padr_bus` to the core. It also owns the post-reset zero-fill sweep of the array.

## Interface
Parameters:
- `WIDTH`, 32: data width per port
- `NUMRDPT`, 2: read ports
- `NUMWRPT`, 3: write ports
- `NUMADDR`, 8192: virtual addresses
- `BITADDR`, 13: virtual address width
- `NUMVROW`, 1024: rows per bank
- `BITVROW`, 10: row index width
- `NUMVBNK`, 8: banks
- `BITVBNK`, 3: bank index width
- `BITPADR`, 13: physical address width, always `BITVBNK+BITVROW`
- `SRAM_DELAY`, 2: macro read latency in cycles, ≥1

Ports:
- `clk` in 1: single clock
- `rst` in 1: **synchronous, active-high reset**
- `pread` in NUMRDPT: read strobe per port
- `rdadr` in NUMRDPT*BITADDR: read virtual address, port i at slice i
- `pwrite` in NUMWRPT: write strobe per port
- `wradr` in NUMWRPT*BITADDR: write virtual address
- `pdin` in NUMWRPT*WIDTH: write data
- `t1_writeA` out NUMWRPT: macro write enable
- `t1_addrA` out NUMWRPT*BITPADR: macro write physical address
- `t1_dinA` out NUMWRPT*WIDTH: macro write data
- `t1_readB` out NUMRDPT: macro read enable
- `t1_addrB` out NUMRDPT*BITPADR: macro read physical address
- `mem_doutB` in NUMRDPT*WIDTH: macro read data, valid `SRAM_DELAY` cycles after `t1_readB`
- `t1_doutB` out NUMRDPT*WIDTH: read data to core
- `vread_vld_bus` out NUMRDPT: read-return valid to core
- `vread_padr_bus` out NUMRDPT*BITPADR: physical address of returned read
- `wr_conflict` out 1: one-cycle pulse on a same-cycle duplicate write address
- `init_done` out 1: array zero-fill complete

## Operation
- Address map: bank = `adr[BITVBNK-1:0]`; row = `adr[BITADDR-1:BITVBNK]`; padr = `{bank,row}`.
- FSM states:
  - INIT: entered on `rst`; 14-bit-wide-enough counter `icnt` (BITADDR+1 bits) walks 0..NUMADDR-1 one per cycle. Port 0 drives `t1_writeA[0]=1`, `t1_addrA`=map(icnt), `t1_dinA`=0. All other macro strobes are 0, and `pread`/`pwrite` are ignored.
  - RUN: entered the cycle after `icnt==NUMADDR-1` is written; `init_done=1`.
  - No exit from RUN except `rst`.
- RUN writes: `t1_writeA[i]=pwrite[i]` combinationally, with mapped address and data passed through.
- Duplicate write address among asserted ports in the same cycle: highest index wins, lower-index strobes are suppressed, and `wr_conflict` pulses in the next cycle.
- RUN reads: `t1_readB[i]=pread[i]` combinationally, with mapped address.
- Per-port shift pipe of depth `SRAM_DELAY` carries (valid, padr).
- Read-return outputs: `vread_vld_bus[i]` = pipe tail valid; `vread_padr_bus` = pipe tail padr; `t1_doutB[i]` = `mem_doutB[i]` when tail valid, else 0.
- Read and write to the same address in the same cycle: the read returns pre-write data. There is no forwarding here.

## Timing
- Reset values: `init_done=0`, `vread_vld_bus=0`, `vread_padr_bus=0`, `t1_doutB=0`, `wr_conflict=0`, pipes cleared, `icnt=0`.
- Macro strobes are 0 during the `rst` cycle.
- First INIT write occurs in the first cycle with `rst` low. `init_done` rises exactly NUMADDR cycles later.
- Read latency: `pread` at cycle T gives `vread_vld_bus` at T+SRAM_DELAY. Back-to-back reads every cycle are supported with full throughput.
- `rst` asserted mid-INIT or mid-RUN: pipes flush in the same edge, in-flight reads are dropped (no valid emitted), and the sweep restarts from 0.
- `pread`/`pwrite` arriving while `init_done=0` are dropped silently.

## Structure
- Shared package `mrpnwp_pkg`:
  - FSM enum `{INIT, RUN}`
  - function `vadr2padr` (address map)
  - localparam check `BITPADR==BITVBNK+BITVROW`
- Sub-module `mrpnwp_rd_dly`: one-port valid/padr delay line parameterized by `SRAM_DELAY`, instantiated NUMRDPT times.

## Test plan
- Reset release with NUMADDR=16: exactly 16 port-0 writes of 0 at padr map(0..15), then `init_done=1` on cycle 17. All other strobes stay low.
- Write addr 5 = 0xA5A5 on port 1, then read addr 5 on port 0 at T. The model returns 0xA5A5: `vread_vld_bus[0]=1` at T+2, `vread_padr_bus`={bank 5, row 0}, no valid at T+1 or T+3.
- Reads every cycle on both ports for 20 cycles: 20 valids per port, each arriving 2 cycles after its request in order, `t1_doutB=0` whenever valid is low.
- Ports 0 and 2 both write addr 9 in the same cycle: only `t1_writeA[2]` asserts, and `wr_conflict` pulses one cycle later.
- Read issued at T, `rst` asserted at T+1: no `vread_vld_bus` at T+2, and INIT restarts from `icnt=0`.
- `pread`/`pwrite` held high during INIT: no `t1_readB`, no extra `t1_writeA`, and no valids.
